// File: rtl/ddr3_test_seq_ctrl.sv
//==========================================================================
// Module      : ddr3_test_seq_ctrl
// Description : Sequencer for the DDR3 self-test datapath. After
//               calibration, each start pulse runs one pass: write a
//               deterministic pattern into the write FIFO, wait a
//               programmable gap, enable memory reads, then drain the
//               read FIFO and check every word against the pattern.
//
// Ports       : clk, rst_n          clock / async active-low reset
//               calib_done         DDR3 calibration complete
//               start              one-cycle pass start pulse
//               wr_en, wr_data     write FIFO port
//               rd_mem_enable      lets the DDR3 read path fill the FIFO
//               rd_valid, rd_en,   read FIFO port (rd_data valid one
//               rd_data            cycle after rd_en)
//               busy, done, pass   pass status
//               err_cnt            saturating mismatch count
//               first_err_idx      check index of the first mismatch
//
// Build option: DDR3_TEST_LFSR_EN  selects a 16-bit Fibonacci LFSR
//               pattern (taps 16,14,13,11) instead of START_VAL + index.
//
// Revision    : 1.0 - initial release
//==========================================================================
`default_nettype none

module ddr3_test_seq_ctrl #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned WR_NUM    = 1300,
    parameter int unsigned RD_NUM    = 1000,
    parameter int unsigned GAP_CYC   = 64,
    parameter int unsigned START_VAL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              calib_done,
    input  logic              start,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_mem_enable,
    input  logic              rd_valid,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [15:0]       first_err_idx
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_CAL = 3'd1,
        ST_WRITE    = 3'd2,
        ST_GAP      = 3'd3,
        ST_READ     = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t            r_state;
    logic [15:0]       r_wr_cnt;
    logic [15:0]       r_gap_cnt;
    logic [15:0]       r_rd_issued;
    logic [15:0]       r_chk_cnt;
    logic              r_chk_vld;

    logic              w_start_fire;
    logic              w_wr_fire;
    logic              w_chk_fire;
    logic              w_gap_end;
    logic              w_mismatch;
    logic [16:0]       w_rd_total;
    logic [DATA_W-1:0] w_wr_pat;
    logic [DATA_W-1:0] w_chk_pat;

    assign w_start_fire = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_wr_fire    = (r_state == ST_WRITE) && calib_done;
    assign w_chk_fire   = r_chk_vld && ((r_state == ST_READ) || (r_state == ST_DRAIN));
    // Leave GAP after GAP_CYC cycles; GAP_CYC=0 still spends one cycle here.
    assign w_gap_end    = ({1'b0, r_gap_cnt} + 17'd1) >= 17'(GAP_CYC);
    // Reads issued so far including the one (if any) on the bus this cycle.
    assign w_rd_total   = {1'b0, r_rd_issued} + {16'd0, rd_en};
    assign w_mismatch   = (rd_data != w_chk_pat);

`ifdef DDR3_TEST_LFSR_EN
    localparam logic [15:0] C_SEED_RAW = 16'(START_VAL);
    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0] C_SEED     = (C_SEED_RAW == 16'h0000) ? 16'h0001 : C_SEED_RAW;

    logic [15:0] r_wr_lfsr;
    logic [15:0] r_chk_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [DATA_W-1:0] lfsr_fit(input logic [15:0] s);
        logic [DATA_W+15:0] ext;
        ext = {{DATA_W{1'b0}}, s};
        return ext[DATA_W-1:0];
    endfunction

    assign w_wr_pat  = lfsr_fit(r_wr_lfsr);
    assign w_chk_pat = lfsr_fit(r_chk_lfsr);

    // Writer and checker each own an LFSR, stepped once per word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_lfsr  <= C_SEED;
            r_chk_lfsr <= C_SEED;
        end else if (w_start_fire) begin
            r_wr_lfsr  <= C_SEED;
            r_chk_lfsr <= C_SEED;
        end else begin
            if (w_wr_fire)  r_wr_lfsr  <= lfsr_step(r_wr_lfsr);
            if (w_chk_fire) r_chk_lfsr <= lfsr_step(r_chk_lfsr);
        end
    end
`else
    localparam logic [DATA_W-1:0] C_START = DATA_W'(START_VAL);

    assign w_wr_pat  = C_START + DATA_W'(r_wr_cnt);
    assign w_chk_pat = C_START + DATA_W'(r_chk_cnt);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_wr_cnt      <= 16'd0;
            r_gap_cnt     <= 16'd0;
            r_rd_issued   <= 16'd0;
            r_chk_cnt     <= 16'd0;
            r_chk_vld     <= 1'b0;
            wr_en         <= 1'b0;
            wr_data       <= '0;
            rd_mem_enable <= 1'b0;
            rd_en         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= 16'd0;
            first_err_idx <= 16'd0;
        end else begin
            r_chk_vld <= rd_en;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state       <= ST_WAIT_CAL;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_cnt       <= 16'd0;
                        first_err_idx <= 16'd0;
                        rd_mem_enable <= 1'b0;
                        r_wr_cnt      <= 16'd0;
                        r_gap_cnt     <= 16'd0;
                        r_rd_issued   <= 16'd0;
                        r_chk_cnt     <= 16'd0;
                    end
                end

                ST_WAIT_CAL: begin
                    if (calib_done) r_state <= ST_WRITE;
                end

                // A calib_done drop pauses the writer without losing its place.
                ST_WRITE: begin
                    wr_en <= calib_done;
                    if (calib_done) begin
                        wr_data  <= w_wr_pat;
                        r_wr_cnt <= r_wr_cnt + 16'd1;
                        if (r_wr_cnt == 16'(WR_NUM - 1)) r_state <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    wr_en <= 1'b0;
                    if (w_gap_end) begin
                        r_state       <= ST_READ;
                        rd_mem_enable <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end

                // Counting the enable already on the bus keeps the total at
                // exactly RD_NUM even when rd_valid stays high.
                ST_READ: begin
                    r_rd_issued <= w_rd_total[15:0];
                    rd_en       <= rd_valid && (w_rd_total < 17'(RD_NUM));
                    if (w_rd_total == 17'(RD_NUM)) r_state <= ST_DRAIN;
                end

                ST_DRAIN: begin
                    rd_en <= 1'b0;
                    if (r_chk_cnt == 16'(RD_NUM)) begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_cnt == 16'd0);
                    end
                end

                default: r_state <= ST_IDLE;
            endcase

            if (w_chk_fire) begin
                r_chk_cnt <= r_chk_cnt + 16'd1;
                if (w_mismatch) begin
                    if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                    // err_cnt saturates rather than wrapping, so zero means no error yet.
                    if (err_cnt == 16'd0) first_err_idx <= r_chk_cnt;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/ddr3_test_seq_ctrl.md
Name: ddr3_test_seq_ctrl

Overview:
Sequencer for the DDR3 self-test datapath. After DDR3 calibration it runs one test pass per start pulse:
- writes a deterministic data pattern into the write FIFO;
- waits a programmable gap, then enables memory reads;
- drains the read FIFO and checks every returned word against the regenerated pattern.

It reports busy/done/pass, a saturating error count and the index of the first mismatch. It sits between the top-level test logic and the DDR3 write/read FIFO ports.

Parameters:
DATA_W, 16, FIFO data width
WR_NUM, 1300, words written per pass (1..65535)
RD_NUM, 1000, words read and checked per pass (1..WR_NUM)
GAP_CYC, 64, clk cycles between the last write and read enable (0..65535)
START_VAL, 0, first pattern value

Ports:
clk  in  1  FIFO-side clock
rst_n  in  1  asynchronous active-low reset
calib_done  in  1  DDR3 calibration complete
start  in  1  one-cycle pulse; starts a pass
wr_en  out  1  write FIFO write enable
wr_data  out  DATA_W  write FIFO data
rd_mem_enable  out  1  allows the DDR3 read path to fill the read FIFO
rd_valid  in  1  read FIFO holds data
rd_en  out  1  read FIFO read enable
rd_data  in  DATA_W  read FIFO data, valid 1 cycle after rd_en
busy  out  1  pass in progress
done  out  1  pass finished, held until the next start
pass  out  1  done and err_cnt==0
err_cnt  out  16  mismatch count, saturates at 16'hFFFF
first_err_idx  out  16  check index of the first mismatch; 0 when there is none

Behaviour:
- Clock/reset: single clock domain clk. Reset is asynchronous, active-low, on rst_n. All outputs are registered.
- Reset state: every output is 0 and the FSM is in IDLE.
- States: IDLE, WAIT_CAL, WRITE, GAP, READ, DRAIN, DONE.
- IDLE/DONE + start:
  - go to WAIT_CAL;
  - clear done, pass, err_cnt, first_err_idx and all internal counters;
  - set busy=1.
- start while busy is ignored.
- WAIT_CAL: move to WRITE on the first cycle calib_done=1.
- WRITE:
  - wr_en=1 on every cycle calib_done=1.
  - wr_data takes the pattern value for index wr_cnt (0..WR_NUM-1).
  - wr_cnt advances only on cycles with wr_en=1.
  - If calib_done drops, wr_en=0 on the next cycle and the FSM holds (pause). It resumes with the same wr_data; no word is skipped or repeated.
  - After the write at index WR_NUM-1: wr_en=0 next cycle, go to GAP.
- GAP:
  - Count GAP_CYC cycles, then go to READ.
  - GAP_CYC=0 gives a single-cycle transit.
- READ:
  - rd_mem_enable=1; it stays 1 through DRAIN and DONE and clears on the next start.
  - Registered rd_en: asserted next cycle iff rd_valid=1 and (rd_issued + rd_en) < RD_NUM.
  - This guarantees exactly RD_NUM enables and never over-reads, including rd_valid high for a long burst.
  - When rd_issued reaches RD_NUM, go to DRAIN.
- Checking (READ and DRAIN):
  - chk_vld is rd_en delayed 1 cycle.
  - On chk_vld, compare rd_data with the pattern value for index chk_cnt, then increment chk_cnt.
  - On mismatch, err_cnt+1, saturating at 16'hFFFF.
  - On the first mismatch only, first_err_idx=chk_cnt.
- DRAIN: once chk_cnt reaches RD_NUM, go to DONE.
- DONE:
  - busy=0, done=1, pass=(err_cnt==0).
  - Outputs are held until start or reset.
- Pattern (default): START_VAL + index, truncated to DATA_W bits, wrapping modulo 2^DATA_W.
- Reset mid-pass: immediate return to the reset state. No partial flags survive.
- calib_done is not monitored in READ/DRAIN.

Optional Feature:
DDR3_TEST_LFSR_EN
- Defined:
  - The pattern is a Fibonacci LFSR: 16-bit, taps 16,14,13,11, zero-extended/truncated to DATA_W.
  - Seed is START_VAL; seed 0 is forced to 16'h0001.
  - The writer and the checker each hold their own LFSR, advanced once per written/checked word.
- Undefined: incrementing pattern as described in Behaviour.

Test Plan:
- Defaults, calib_done=1, start, rd_valid held 1 after read enable → exactly 1300 wr_en cycles with wr_data 0..1299, exactly 1000 rd_en cycles; done=1, pass=1, err_cnt=0.
- calib_done low for 10 cycles after 500 writes → wr_en gap of 10 cycles, wr_data resumes at 500, total writes 1300.
- Read model returns word 37 as 0xFFFF and word 900 corrupted → err_cnt=2, first_err_idx=37, pass=0.
- rd_valid toggling 1-on/2-off → rd_en count is still exactly 1000, never asserted while rd_valid was 0 the prior cycle; done only after the 1000th check.
- start during WRITE is ignored; rst_n low at chk_cnt=400 → all outputs 0 immediately; a new start gives a clean pass with pass=1.
- With DDR3_TEST_LFSR_EN, START_VAL=0 → first wr_data=0x0001, second=0x0002 per taps; error-free loopback gives pass=1.
